// File: rtl/rr_packet_arbiter_pkg.sv
// Shared router definitions for the output-port arbiters: index typedef,
// default requester count, lock state encoding and an index-width helper.
package rr_packet_arbiter_pkg;

    localparam int ROUTER_PORTS    = 5;
    localparam int N_OF_INPUTS_DEF = ROUTER_PORTS;

    typedef logic [$clog2(ROUTER_PORTS)-1:0] arb_idx_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // A single requester still needs a one-bit index so ports never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick_first.sv
// Finds the first set bit of mask at or after start, wrapping modulo N.
// Works for any N, including non-powers of two.
module rr_pick_first
    import rr_packet_arbiter_pkg::*;
#(
    parameter int N     = N_OF_INPUTS_DEF,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

    logic [N-1:0]   rotated;
    logic [IDX_W:0] offset;
    logic [IDX_W:0] sum;
    logic           found;

    // Rotating the doubled mask right by start puts the search origin at bit 0,
    // so the lowest set bit of the result is the offset of the winner from start.
    always_comb begin
        rotated = N'({mask, mask} >> start);
        offset  = '0;
        found   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = (IDX_W+1)'(i);
                found  = 1'b1;
            end
        end
        sum = {1'b0, start} + offset;
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        idx = found ? sum[IDX_W-1:0] : '0;
        for (int j = 0; j < N; j++) begin
            onehot[j] = found && (sum == (IDX_W+1)'(j));
        end
    end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin wormhole arbiter for one router output port: optional
// high-priority class, grant held from the first accepted flit to the tail.
module rr_packet_arbiter
    import rr_packet_arbiter_pkg::*;
#(
    parameter int N_OF_INPUTS = N_OF_INPUTS_DEF,
    parameter bit HP_EN       = 1'b1,
    parameter int IDX_W       = idx_width(N_OF_INPUTS)
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic [N_OF_INPUTS-1:0] req_i,
    input  logic [N_OF_INPUTS-1:0] hp_i,
    input  logic                   xfer_i,
    input  logic                   last_i,
    output logic [N_OF_INPUTS-1:0] grant_o,
    output logic [IDX_W-1:0]       grant_idx_o,
    output logic                   locked_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OF_INPUTS - 1);

    arb_state_t             state;
    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       lock_idx;
    logic [N_OF_INPUTS-1:0] hp_req;
    logic [N_OF_INPUTS-1:0] cand;
    logic [N_OF_INPUTS-1:0] pick_onehot;
    logic [N_OF_INPUTS-1:0] lock_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       next_ptr;
    logic                   grant_any;

    // The hp class only narrows the candidates when someone in it is asking.
    always_comb begin
        hp_req = req_i & hp_i;
        cand   = (HP_EN && (hp_req != '0)) ? hp_req : req_i;
    end

    rr_pick_first #(
        .N     (N_OF_INPUTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .mask   (cand),
        .start  (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    always_comb begin
        for (int j = 0; j < N_OF_INPUTS; j++) begin
            lock_onehot[j] = (lock_idx == IDX_W'(j));
        end
    end

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        locked_o    = 1'b0;
        if (!arst) begin
            locked_o = (state == ARB_LOCKED);
            if (state == ARB_LOCKED) begin
                grant_o     = lock_onehot;
                grant_idx_o = lock_idx;
            end else begin
                grant_o     = pick_onehot;
                grant_idx_o = pick_idx;
            end
        end
    end

    assign grant_any = |grant_o;
    assign next_ptr  = (grant_idx_o == LAST_IDX) ? '0 : grant_idx_o + 1'b1;

    // A transfer with nothing granted is ignored so a misbehaving downstream
    // cannot corrupt the rotation or lock state.
    always_ff @(posedge clk) begin
        if (arst) begin
            state    <= ARB_IDLE;
            ptr      <= '0;
            lock_idx <= '0;
        end else if (xfer_i && grant_any) begin
            if (last_i) begin
                state <= ARB_IDLE;
                ptr   <= next_ptr;
            end else if (state == ARB_IDLE) begin
                state    <= ARB_LOCKED;
                lock_idx <= grant_idx_o;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!arst) begin
            assert (!(xfer_i && !grant_any))
                else $error("rr_packet_arbiter: xfer_i asserted with no grant");
            assert ($onehot0(grant_o))
                else $error("rr_packet_arbiter: grant_o not one-hot");
        end
    end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Scoreboard bench: a 4-input hp-enabled arbiter and a 3-input pure
// round-robin arbiter driven cycle by cycle against hand-derived grants.
module tb_rr_packet_arbiter;

    typedef struct {
        string      tag;
        bit         use3;
        logic [3:0] grant;
        logic [1:0] idx;
        logic       locked;
    } exp_t;

    logic       clk;
    logic       arst;
    logic [3:0] req4, hp4;
    logic       xfer4, last4;
    logic [3:0] grant4;
    logic [1:0] idx4;
    logic       locked4;
    logic [2:0] req3, hp3;
    logic       xfer3, last3;
    logic [2:0] grant3;
    logic [1:0] idx3;
    logic       locked3;

    exp_t sb[$];
    int   checks;
    int   failures;

    rr_packet_arbiter #(.N_OF_INPUTS(4), .HP_EN(1'b1)) dut4 (
        .clk         (clk),
        .arst        (arst),
        .req_i       (req4),
        .hp_i        (hp4),
        .xfer_i      (xfer4),
        .last_i      (last4),
        .grant_o     (grant4),
        .grant_idx_o (idx4),
        .locked_o    (locked4)
    );

    rr_packet_arbiter #(.N_OF_INPUTS(3), .HP_EN(1'b0)) dut3 (
        .clk         (clk),
        .arst        (arst),
        .req_i       (req3),
        .hp_i        (hp3),
        .xfer_i      (xfer3),
        .last_i      (last3),
        .grant_o     (grant3),
        .grant_idx_o (idx3),
        .locked_o    (locked3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of stimulus on the selected arbiter (the other idles),
    // queues the expected outputs, then samples mid-cycle and scores them.
    task automatic applyStimulus(input bit use3, input logic rst,
                                 input logic [3:0] req, input logic [3:0] hp,
                                 input logic xfer, input logic last,
                                 input logic [3:0] eg, input logic [1:0] ei,
                                 input logic el, input string tag);
        exp_t e;
        exp_t got;
        logic [3:0] og;
        logic [1:0] oi;
        logic       ol;
        @(negedge clk);
        arst  = rst;
        req4  = use3 ? 4'b0 : req;
        hp4   = use3 ? 4'b0 : hp;
        xfer4 = use3 ? 1'b0 : xfer;
        last4 = use3 ? 1'b0 : last;
        req3  = use3 ? req[2:0] : 3'b0;
        hp3   = use3 ? hp[2:0] : 3'b0;
        xfer3 = use3 ? xfer : 1'b0;
        last3 = use3 ? last : 1'b0;
        e.tag = tag; e.use3 = use3; e.grant = eg; e.idx = ei; e.locked = el;
        sb.push_back(e);
        #2;
        got = sb.pop_front();
        og = got.use3 ? {1'b0, grant3} : grant4;
        oi = got.use3 ? idx3 : idx4;
        ol = got.use3 ? locked3 : locked4;
        checkOutput({got.tag, "_grant"}, 32'(og), 32'(got.grant));
        checkOutput({got.tag, "_idx"}, 32'(oi), 32'(got.idx));
        checkOutput({got.tag, "_locked"}, 32'(ol), 32'(got.locked));
        checkOutput({got.tag, "_onehot"}, 32'($onehot0(og)), 32'd1);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        arst = 1'b1;
        req4 = '0; hp4 = '0; xfer4 = 1'b0; last4 = 1'b0;
        req3 = '0; hp3 = '0; xfer3 = 1'b0; last3 = 1'b0;
        repeat (2) @(posedge clk);

        applyStimulus(0, 1, 4'b1111, 4'b0000, 0, 0, 4'b0000, 2'd0, 0, "rst_hold");
        applyStimulus(0, 0, 4'b1111, 4'b0000, 1, 1, 4'b0001, 2'd0, 0, "rr0");
        applyStimulus(0, 0, 4'b1111, 4'b0000, 1, 1, 4'b0010, 2'd1, 0, "rr1");
        applyStimulus(0, 0, 4'b1111, 4'b0000, 1, 1, 4'b0100, 2'd2, 0, "rr2");
        applyStimulus(0, 0, 4'b1111, 4'b0000, 1, 1, 4'b1000, 2'd3, 0, "rr3");
        applyStimulus(0, 0, 4'b1111, 4'b0000, 1, 1, 4'b0001, 2'd0, 0, "rr_wrap");

        applyStimulus(0, 0, 4'b0110, 4'b0000, 1, 0, 4'b0010, 2'd1, 0, "lock_head");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 4'b1111, 4'b1000, 0, 0, 4'b0010, 2'd1, 1, $sformatf("lock_hold%0d", k));
        end
        applyStimulus(0, 0, 4'b1111, 4'b0000, 1, 1, 4'b0010, 2'd1, 1, "lock_tail");
        applyStimulus(0, 0, 4'b1111, 4'b0000, 0, 0, 4'b0100, 2'd2, 0, "after_tail");

        applyStimulus(0, 1, 4'b1011, 4'b1010, 0, 0, 4'b0000, 2'd0, 0, "rst2");
        applyStimulus(0, 0, 4'b1011, 4'b1010, 1, 1, 4'b0010, 2'd1, 0, "hp_first");
        applyStimulus(0, 0, 4'b1011, 4'b1010, 0, 0, 4'b1000, 2'd3, 0, "hp_rotate");
        applyStimulus(0, 0, 4'b1011, 4'b1010, 1, 0, 4'b1000, 2'd3, 0, "drop_head");
        applyStimulus(0, 0, 4'b0000, 4'b0000, 0, 0, 4'b1000, 2'd3, 1, "drop_hold");
        applyStimulus(0, 0, 4'b0000, 4'b0000, 1, 1, 4'b1000, 2'd3, 1, "drop_tail");
        applyStimulus(0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 2'd0, 0, "drop_idle");
        applyStimulus(0, 0, 4'b1111, 4'b0000, 0, 0, 4'b0001, 2'd0, 0, "drop_ptr0");

        applyStimulus(0, 0, 4'b0010, 4'b0000, 1, 0, 4'b0010, 2'd1, 0, "mid_head");
        applyStimulus(0, 0, 4'b0010, 4'b0000, 0, 0, 4'b0010, 2'd1, 1, "mid_hold");
        applyStimulus(0, 1, 4'b0010, 4'b0000, 0, 0, 4'b0000, 2'd0, 0, "mid_rst");
        applyStimulus(0, 0, 4'b1111, 4'b0000, 0, 0, 4'b0001, 2'd0, 0, "mid_ptr0");
        applyStimulus(0, 0, 4'b0010, 4'b0000, 0, 0, 4'b0010, 2'd1, 0, "mid_unlocked");
        applyStimulus(0, 0, 4'b1111, 4'b0100, 0, 0, 4'b0100, 2'd2, 0, "stall0");
        applyStimulus(0, 0, 4'b1111, 4'b0100, 0, 0, 4'b0100, 2'd2, 0, "stall1");

        for (int k = 0; k < 7; k++) begin
            applyStimulus(1, 0, 4'b0111, 4'b0100, 1, 1, 4'(1 << (k % 3)), 2'(k % 3), 0,
                          $sformatf("n3_rr%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
